// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: time base and button levels in, BCD count and FSM status out.
interface stopwatch_ctrl_if;
  logic        slow_clk;
  logic        btn_start;
  logic        btn_clear;
  logic [15:0] bcd;
  logic [1:0]  state;
  logic        running;
  logic        ovf;

  // The driver of the buttons and time base.
  modport master (
    output slow_clk,
    output btn_start,
    output btn_clear,
    input  bcd,
    input  state,
    input  running,
    input  ovf
  );

  // The stopwatch controller itself.
  modport slave (
    input  slow_clk,
    input  btn_start,
    input  btn_clear,
    output bcd,
    output state,
    output running,
    output ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch controller.
// The slow time base and both buttons are asynchronous to clk. Each one is synchronized,
// and a single-cycle rising-edge pulse is derived from it. Those pulses drive an
// IDLE/RUN/PAUSE FSM and a BCD counter that either wraps or saturates at 9999.
module stopwatch_ctrl #(
  parameter bit WRAP = 1'b1  // 1: 9999 wraps to 0000; 0: saturate at 9999 and pause
) (
  input logic              clk,
  input logic              rst_n,
  stopwatch_ctrl_if.slave  sw
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  // Bit 0: slow_clk, bit 1: btn_start, bit 2: btn_clear.
  // Buttons reset high, so a button held through reset release produces no edge.
  localparam logic [2:0] SyncRst = 3'b110;

  localparam logic [15:0] BcdMax = 16'h9999;

  logic [2:0] sync1_q, sync2_q, hist_q;
  logic [2:0] pulse_d, pulse_q;

  logic tick, start_e, clear_e;

  state_e      state_d, state_q;
  logic [15:0] bcd_d, bcd_q;
  logic        ovf_d, ovf_q;
  logic [15:0] bcd_inc;

  // BCD +1: digits at 9 (or an out-of-range value) roll to 0 and carry onward.
  function automatic logic [15:0] bcd_plus_one(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Two-flop synchronizer plus history flop for the time base and both buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SyncRst;
      sync2_q <= SyncRst;
      hist_q  <= SyncRst;
    end else begin
      sync1_q <= {sw.btn_clear, sw.btn_start, sw.slow_clk};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Rising-edge detect: exactly one pulse per synchronized 0->1 transition.
  always_comb begin
    pulse_d = sync2_q & ~hist_q;
  end

  // Edge pulses are registered, so a rise captured at edge N acts on edge N+3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= 3'b000;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  // Name the individual event pulses.
  always_comb begin
    tick    = pulse_q[0];
    start_e = pulse_q[1];
    clear_e = pulse_q[2];
  end

  // Incremented count, computed for every cycle and used only on a counted tick.
  always_comb begin
    bcd_inc = bcd_plus_one(bcd_q);
  end

  // FSM state, count and overflow pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state and count: clear beats everything; in RUN a tick is counted on the same
  // edge that start_e pauses the FSM.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    ovf_d   = 1'b0;
    if (clear_e) begin
      state_d = StIdle;
      bcd_d   = 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_e) state_d = StRun;
        end
        StRun: begin
          if (tick) begin
            if (bcd_q == BcdMax) begin
              ovf_d = 1'b1;
              if (WRAP) begin
                bcd_d = 16'h0000;
              end else begin
                state_d = StPause;
              end
            end else begin
              bcd_d = bcd_inc;
            end
          end
          if (start_e) state_d = StPause;
        end
        StPause: begin
          if (start_e) state_d = StRun;
        end
        default: begin
          state_d = StIdle;
          bcd_d   = 16'h0000;
        end
      endcase
    end
  end

  // Drive the interface outputs straight from the registers.
  always_comb begin
    sw.bcd     = bcd_q;
    sw.state   = state_q;
    sw.running = (state_q == StRun);
    sw.ovf     = ovf_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: one wrapping and one saturating instance share the same stimulus.
// An integer-count model predicts both, and its outputs are compared on every negedge.
module tb_stopwatch_ctrl;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic slow_clk  = 1'b0;
  logic btn_start = 1'b1;
  logic btn_clear = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_w ();
  stopwatch_ctrl_if sw_s ();

  assign sw_w.slow_clk  = slow_clk;
  assign sw_w.btn_start = btn_start;
  assign sw_w.btn_clear = btn_clear;
  assign sw_s.slow_clk  = slow_clk;
  assign sw_s.btn_start = btn_start;
  assign sw_s.btn_clear = btn_clear;

  stopwatch_ctrl #(.WRAP(1'b1)) u_dut_wrap (.clk(clk), .rst_n(rst_n), .sw(sw_w));
  stopwatch_ctrl #(.WRAP(1'b0)) u_dut_sat  (.clk(clk), .rst_n(rst_n), .sw(sw_s));

  // Index 0: wrapping instance, index 1: saturating instance.
  logic [15:0] bcd_o[2];
  logic [1:0]  state_o[2];
  logic        run_o[2];
  logic        ovf_o[2];
  assign bcd_o[0]   = sw_w.bcd;
  assign bcd_o[1]   = sw_s.bcd;
  assign state_o[0] = sw_w.state;
  assign state_o[1] = sw_s.state;
  assign run_o[0]   = sw_w.running;
  assign run_o[1]   = sw_s.running;
  assign ovf_o[0]   = sw_w.ovf;
  assign ovf_o[1]   = sw_s.ovf;

  int checks = 0;
  int errors = 0;

  // Model: plain integer count and state code (0 idle, 1 run, 2 pause).
  int cnt_m[2];
  int st_m[2];
  bit ovf_m[2];
  // Sampled input levels at recent edges, index 0 newest.
  bit h_slow[4];
  bit h_start[4];
  bit h_clear[4];

  int ovf_cnt[2];

  task automatic check(input string name, input int d, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s dut%0d got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'(n / 1000);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt_m[d] = 0;
      st_m[d]  = 0;
      ovf_m[d] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      h_slow[i]  = 1'b0;
      h_start[i] = 1'b1;
      h_clear[i] = 1'b1;
    end
  endtask

  // A rise sampled three edges ago takes effect on this edge.
  task automatic model_step();
    bit tk, se, ce;
    tk = h_slow[2] & ~h_slow[3];
    se = h_start[2] & ~h_start[3];
    ce = h_clear[2] & ~h_clear[3];
    for (int i = 3; i > 0; i--) begin
      h_slow[i]  = h_slow[i-1];
      h_start[i] = h_start[i-1];
      h_clear[i] = h_clear[i-1];
    end
    h_slow[0]  = slow_clk;
    h_start[0] = btn_start;
    h_clear[0] = btn_clear;
    for (int d = 0; d < 2; d++) begin
      ovf_m[d] = 1'b0;
      if (ce) begin
        st_m[d]  = 0;
        cnt_m[d] = 0;
      end else if (st_m[d] == 1) begin
        if (tk) begin
          if (cnt_m[d] == 9999) begin
            ovf_m[d] = 1'b1;
            if (d == 0) cnt_m[d] = 0;
            else st_m[d] = 2;
          end else begin
            cnt_m[d] = cnt_m[d] + 1;
          end
        end
        if (se) st_m[d] = 2;
      end else if (se) begin
        st_m[d] = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          check("bcd", d, bcd_o[d], to_bcd(cnt_m[d]));
          check("state", d, {14'b0, state_o[d]}, 16'(st_m[d]));
          check("running", d, {15'b0, run_o[d]}, {15'b0, st_m[d] == 1});
          check("ovf", d, {15'b0, ovf_o[d]}, {15'b0, ovf_m[d]});
          for (int i = 0; i < 4; i++)
            check("digit_range", d, {15'b0, bcd_o[d][4*i +: 4] > 4'd9}, 16'h0000);
        end
      end
    end
  end

  initial begin
    ovf_cnt[0] = 0;
    ovf_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (ovf_o[d] === 1'b1) ovf_cnt[d]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      slow_clk = 1'b1;
      cyc(1);
      slow_clk = 1'b0;
      cyc(1);
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    cyc(2);
    btn_start = 1'b0;
    cyc(2);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    cyc(2);
    btn_clear = 1'b0;
    cyc(2);
  endtask

  task automatic lit(input string name, input int d, input logic [15:0] bcd_e,
                     input logic [1:0] st_e);
    check({name, "_bcd"}, d, bcd_o[d], bcd_e);
    check({name, "_state"}, d, {14'b0, state_o[d]}, {14'b0, st_e});
    check({name, "_running"}, d, {15'b0, run_o[d]}, {15'b0, st_e == 2'b01});
  endtask

  initial begin
    // Reset with start held high through release: no edge may be seen.
    cyc(3);
    for (int d = 0; d < 2; d++) begin
      lit("reset", d, 16'h0000, 2'b00);
      check("reset_ovf", d, {15'b0, ovf_o[d]}, 16'h0000);
    end
    rst_n = 1'b1;
    cyc(6);
    for (int d = 0; d < 2; d++) lit("held_start", d, 16'h0000, 2'b00);
    btn_start = 1'b0;
    cyc(4);
    for (int d = 0; d < 2; d++) lit("start_fall", d, 16'h0000, 2'b00);

    // Basic count.
    press_start();
    ticks(12);
    cyc(4);
    for (int d = 0; d < 2; d++) lit("count12", d, 16'h0012, 2'b01);

    // Latency: rise sampled at edge N counts on edge N+3.
    slow_clk = 1'b1;
    cyc(1);
    slow_clk = 1'b0;
    cyc(1);
    cyc(1);
    check("latency_n2", 0, bcd_o[0], 16'h0012);
    cyc(1);
    check("latency_n3", 0, bcd_o[0], 16'h0013);

    // Pause / resume.
    press_clear();
    for (int d = 0; d < 2; d++) lit("clear", d, 16'h0000, 2'b00);
    press_start();
    ticks(5);
    cyc(4);
    press_start();
    ticks(3);
    cyc(4);
    for (int d = 0; d < 2; d++) lit("paused", d, 16'h0005, 2'b10);
    press_start();
    ticks(1);
    cyc(4);
    for (int d = 0; d < 2; d++) lit("resumed", d, 16'h0006, 2'b01);

    // Carry chain.
    ticks(993);
    cyc(4);
    for (int d = 0; d < 2; d++) lit("at0999", d, 16'h0999, 2'b01);
    ticks(1);
    cyc(4);
    for (int d = 0; d < 2; d++) lit("carry1000", d, 16'h1000, 2'b01);

    // Wrap vs saturate at 9999.
    ticks(8999);
    cyc(4);
    for (int d = 0; d < 2; d++) lit("at9999", d, 16'h9999, 2'b01);
    ovf_cnt[0] = 0;
    ovf_cnt[1] = 0;
    ticks(1);
    cyc(4);
    lit("wrap", 0, 16'h0000, 2'b01);
    lit("saturate", 1, 16'h9999, 2'b10);
    check("wrap_ovf_pulses", 0, 16'(ovf_cnt[0]), 16'd1);
    check("sat_ovf_pulses", 1, 16'(ovf_cnt[1]), 16'd1);

    // Saturated instance resumes and saturates again; wrapping one pauses.
    ovf_cnt[0] = 0;
    ovf_cnt[1] = 0;
    press_start();
    cyc(1);
    lit("sat_resume", 1, 16'h9999, 2'b01);
    lit("wrap_pause", 0, 16'h0000, 2'b10);
    ticks(1);
    cyc(4);
    lit("sat_again", 1, 16'h9999, 2'b10);
    check("sat_again_ovf", 1, 16'(ovf_cnt[1]), 16'd1);
    check("paused_no_ovf", 0, 16'(ovf_cnt[0]), 16'd0);

    // Priority: start and clear together, then tick with start.
    press_clear();
    press_start();
    ticks(42);
    cyc(4);
    for (int d = 0; d < 2; d++) lit("at0042", d, 16'h0042, 2'b01);
    btn_start = 1'b1;
    btn_clear = 1'b1;
    cyc(2);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    cyc(4);
    for (int d = 0; d < 2; d++) lit("clear_wins", d, 16'h0000, 2'b00);
    press_start();
    ticks(3);
    cyc(4);
    slow_clk  = 1'b1;
    btn_start = 1'b1;
    cyc(1);
    slow_clk = 1'b0;
    cyc(1);
    btn_start = 1'b0;
    cyc(4);
    for (int d = 0; d < 2; d++) lit("tick_start", d, 16'h0004, 2'b10);

    // Randomized stretch against the model.
    repeat (4000) begin
      slow_clk  = 1'($urandom_range(0, 1));
      btn_start = ($urandom_range(0, 15) == 0);
      btn_clear = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    slow_clk  = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    cyc(6);

    // Asynchronous reset mid-run, then a fresh start needs a 0->1 press.
    press_clear();
    press_start();
    ticks(7);
    cyc(4);
    for (int d = 0; d < 2; d++) lit("at0007", d, 16'h0007, 2'b01);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) lit("async_reset", d, 16'h0000, 2'b00);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    for (int d = 0; d < 2; d++) lit("post_reset", d, 16'h0000, 2'b00);
    press_start();
    ticks(2);
    cyc(4);
    for (int d = 0; d < 2; d++) lit("restart", d, 16'h0002, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter WRAP, default 1, meaning: 1 = count wraps 9999->0000; 0 = count saturates at 9999.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; every flop is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port slow_clk, input, 1, the divided time-base clock from the frequency divider, asynchronous to clk.
REQ-005 The block SHALL have port btn_start, input, 1, the active-high start/stop button level (debounced upstream), asynchronous to clk.
REQ-006 The block SHALL have port btn_clear, input, 1, the active-high clear button level (debounced upstream), asynchronous to clk.
REQ-007 The block SHALL have port bcd, output, 16, four BCD digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-008 The block SHALL have port state, output, 2, the FSM state: IDLE=00, RUN=01, PAUSE=10; 11 is never driven.
REQ-009 The block SHALL have port running, output, 1, high exactly when state==RUN.
REQ-010 The block SHALL have port ovf, output, 1, a one-clk pulse when the count passes 9999.

Function
REQ-011 slow_clk SHALL pass through a 2-flop synchronizer plus one history flop; internal tick = sync2 & ~hist, one clk cycle wide, exactly once per slow_clk rising edge.
REQ-012 btn_start and btn_clear SHALL each pass through an identical 2-flop synchronizer plus history flop; start_e and clear_e are one-cycle rising-edge pulses.
REQ-013 Latency: a slow_clk or button rise sampled at clk edge N SHALL produce its pulse in the cycle after edge N+2; the resulting bcd/state update SHALL be visible after edge N+3.
REQ-014 FSM transitions: IDLE --start_e--> RUN; RUN --start_e--> PAUSE; PAUSE --start_e--> RUN; clear_e from any state --> IDLE.
REQ-015 clear_e SHALL set bcd to 0000 on the same edge it moves the FSM to IDLE.
REQ-016 Simultaneous clear_e and start_e SHALL resolve to clear: IDLE, bcd=0000.
REQ-017 In RUN, each tick SHALL increment bcd by one in BCD; a digit at 9 SHALL become 0 and carry into the next digit.
REQ-018 In IDLE and PAUSE, tick SHALL be ignored and bcd held.
REQ-019 A tick coinciding with start_e in RUN SHALL be counted on that same edge, and the FSM SHALL enter PAUSE on that edge.
REQ-020 A tick coinciding with clear_e SHALL be discarded: bcd=0000.
REQ-021 With WRAP=1, a tick at 9999 in RUN SHALL set bcd to 0000, pulse ovf for one cycle and remain in RUN.
REQ-022 With WRAP=0, a tick at 9999 in RUN SHALL hold bcd at 9999, pulse ovf for one cycle and move the FSM to PAUSE.
REQ-023 With WRAP=0, start_e in PAUSE at 9999 SHALL enter RUN; the next tick SHALL repeat REQ-022.
REQ-024 Every BCD digit SHALL remain within 0..9 at all times.

Reset
REQ-025 On rst_n low, asynchronously: bcd=0000, state=IDLE, running=0, ovf=0, slow_clk synchronizer and history flops=0.
REQ-026 On rst_n low, the button synchronizer and history flops SHALL reset to 1, so a button held through reset release generates no edge.
REQ-027 Reset asserted mid-count SHALL abort the count immediately, without waiting for a clk edge.
REQ-028 After rst_n rises, the first start_e SHALL require a button 0->1 transition.

Verification
REQ-029 Basic count, WRAP=1: reset, pulse btn_start, apply 12 slow_clk rises -> bcd=0x0012, state=01, running=1.
REQ-030 Pause/resume: in RUN at bcd=0x0005, press start, apply 3 slow_clk rises -> bcd stays 0x0005 and state=10; press start again, apply 1 rise -> bcd=0x0006.
REQ-031 Carry chain: preload by ticking to 0x0999, then 1 tick -> bcd=0x1000.
REQ-032 Wrap and saturate at 9999: WRAP=1, 1 tick -> bcd=0x0000, one-cycle ovf, state=01; WRAP=0, 1 tick -> bcd=0x9999, one-cycle ovf, state=10.
REQ-033 Priority: start_e and clear_e in the same cycle while RUN at 0x0042 -> bcd=0x0000, state=00; tick plus start_e in the same cycle in RUN -> count increments and state=10.
REQ-034 Reset behaviour: hold btn_start high across rst_n release -> state stays 00; assert rst_n mid-RUN -> bcd=0x0000 and state=00 asynchronously.
